firtap_mc: RTL and testbench
============================

# firtap_mc

Multi-channel, coefficient-reloadable systolic FIR tap: the next-generation building block for the transposed/systolic FIR chain. Each instance multiplies a signed sample by the active coefficient of that sample's channel and adds the partial sum from the previous tap. It forwards the sample, a channel tag and valid flags to the next tap. Coefficients are double-buffered per channel so a whole chain can be retuned atomically without glitching the output stream.

## Interface
- XW, 18, sample width (signed)
- COEFW, 25, coefficient width (signed)
- OUTW, 48, partial-sum width (signed); must be ≥ XW+COEFW
- NCH, 1, interleaved channel count (≥1)
- CHW, max(1,$clog2(NCH)), channel tag width (derived localparam)
- SAMPLE_SHIFT, 1, sample-path latency in clocks (≥1)
- SUM_SHIFT, 2, sum-path latency in clocks (≥2)

- clk  in  1  single clock; all logic on the rising edge
- rstn  in  1  asynchronous, active-low reset
- in_valid  in  1  qualifies inX, in_ch and inSum
- in_ch  in  CHW  channel tag of inX/inSum
- inX  in  XW  sample
- inSum  in  OUTW  partial sum from the previous tap
- outX_valid  out  1  in_valid delayed by SAMPLE_SHIFT
- outX_ch  out  CHW  in_ch delayed by SAMPLE_SHIFT
- outX  out  XW  inX delayed by SAMPLE_SHIFT
- outSum_valid  out  1  in_valid delayed by SUM_SHIFT
- outSum  out  OUTW  MAC result delayed by SUM_SHIFT
- coef_wr  in  1  write strobe for the shadow coefficient bank
- coef_wr_ch  in  CHW  shadow entry to write
- coef_wr_data  in  COEFW  coefficient value
- coef_swap  in  1  one-cycle pulse: copy all shadow entries to the active bank

## Operation
- Two banks of NCH coefficients: shadow (written via coef_wr) and active (read by the MAC).
- Coefficient write: coef_wr=1 stores coef_wr_data into shadow[coef_wr_ch] at the clock edge.
  - coef_wr_ch ≥ NCH: write ignored.
  - in_ch ≥ NCH with in_valid=1: product forced to 0.
- Swap: coef_swap=1 copies every shadow entry into active at the clock edge.
  - Simultaneous coef_wr and coef_swap: active receives the pre-write shadow value; shadow takes the new value.
- MAC pipeline, two stages:
  - Stage 0 (combinational): coef = active[in_ch].
  - Stage 1: prod ← sext(inX)·sext(coef) (signed, full precision, sign-extended to OUTW) when in_valid, else 0; sum_d ← inSum when in_valid, else 0; v1 ← in_valid.
  - Stage 2: acc ← sum_d + prod, modulo 2^OUTW (two's-complement wrap, no saturation); v2 ← v1.
  - acc/v2 then pass through SUM_SHIFT−2 plain registers to outSum/outSum_valid.
- Sample path: inX, in_ch and in_valid pass through a SAMPLE_SHIFT-deep register chain, unconditionally every clock.
- No backpressure; the block is fully streaming, one sample per clock max.

## Timing
- Reset (rstn=0, asynchronous assert, synchronous release): every pipeline register, both coefficient banks, all outputs and all valids go to 0.
  - Reset mid-stream discards in-flight data.
  - First output is valid no earlier than SUM_SHIFT clocks after the first post-reset in_valid.
- Sample accepted at edge t produces:
  - outX/outX_ch/outX_valid at edge t+SAMPLE_SHIFT;
  - outSum/outSum_valid at edge t+SUM_SHIFT.
- Cycles with in_valid=0 produce outSum=0 with outSum_valid=0 at the matching output cycle.
- Coefficient visibility:
  - A sample accepted at the same edge as coef_swap uses the old active coefficient.
  - Samples at later edges use the new one.
  - A shadow write at edge t becomes swappable from edge t+1.
- Back-to-back swaps are legal; each copies the shadow content at its own edge.

## Test plan
- Reset: drive random inputs with rstn=0, then release → all outputs 0. Swap with empty shadow → active stays 0, so outSum = inSum for valid inputs.
- Single-channel MAC (NCH=1, SUM_SHIFT=2, SAMPLE_SHIFT=1): write coef 3, swap, then inX=5, inSum=10 at t → outSum=25 and outSum_valid=1 at t+2; outX=5 at t+1.
- Signed and wrap: coef=−4, inX=−2, inSum=0 → 8. Separately, coef=1, inX=1, inSum=2^47−1 → outSum=−2^47 (0x800000000000).
- Interleaved channels (NCH=4, SUM_SHIFT=4, SAMPLE_SHIFT=2):
  - Coefs {1,2,3,4}, repeating ch 0..3 with inX=10, inSum=0 → outSum sequence 10,20,30,40 at 4-cycle offset.
  - outX_ch sequence 0,1,2,3 at 2-cycle offset.
- Atomic swap:
  - Write new shadow values while streaming, with no swap → outputs unchanged.
  - Pulse coef_swap at t → sample at t uses old coef, sample at t+1 uses new.
  - Simultaneous write+swap on ch 0 (shadow 7, write 9) → active=7; next swap → active=9.
- Gaps and mid-stream reset:
  - in_valid pattern 1,0,1 → outSum_valid 1,0,1 with outSum=0 in the gap.
  - Assert rstn=0 with 3 samples in flight → no valid outputs emerge after release.

Source files
------------

// File: rtl/firtap_mc.sv
// firtap_mc -- one tap of a transposed/systolic FIR chain with interleaved
// channels and double-buffered, atomically swappable coefficients.
//
// Each accepted sample is multiplied by the active coefficient of its
// channel. The previous tap's partial sum is added to that product. The
// sample, its channel tag and its valid flag are forwarded to the next tap.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   in_valid/in_ch/inX/inSum  input sample, channel tag, previous partial sum
//   outX_valid/outX_ch/outX   forwarded sample, SAMPLE_SHIFT clocks later
//   outSum_valid/outSum       MAC result, SUM_SHIFT clocks later
//   coef_wr/coef_wr_ch/coef_wr_data  write one shadow coefficient entry
//   coef_swap                 copy the whole shadow bank into the active bank
module firtap_mc #(
  parameter int XW           = 18,
  parameter int COEFW        = 25,
  parameter int OUTW         = 48,
  parameter int NCH          = 1,
  parameter int SAMPLE_SHIFT = 1,
  parameter int SUM_SHIFT    = 2,
  localparam int CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  input  logic [CHW-1:0]          in_ch,
  input  logic signed [XW-1:0]    inX,
  input  logic signed [OUTW-1:0]  inSum,
  output logic                    outX_valid,
  output logic [CHW-1:0]          outX_ch,
  output logic signed [XW-1:0]    outX,
  output logic                    outSum_valid,
  output logic signed [OUTW-1:0]  outSum,
  input  logic                    coef_wr,
  input  logic [CHW-1:0]          coef_wr_ch,
  input  logic signed [COEFW-1:0] coef_wr_data,
  input  logic                    coef_swap
);

  logic signed [COEFW-1:0] r_shadow [NCH];
  logic signed [COEFW-1:0] r_active [NCH];

  // The swap copies the shadow contents as they were before this edge. A
  // write at the same edge therefore reaches only the shadow bank. Channel
  // numbers at or above NCH match no entry, so such writes are dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (coef_swap) r_active[i] <= r_shadow[i];
        if (coef_wr && (coef_wr_ch == CHW'(i))) r_shadow[i] <= coef_wr_data;
      end
    end
  end

  // Active coefficient lookup. A channel tag at or above NCH selects no
  // entry. Its coefficient is 0, so its product is 0.
  logic signed [COEFW-1:0] w_coef;
  always_comb begin
    w_coef = '0;
    for (int i = 0; i < NCH; i++) begin
      if (in_ch == CHW'(i)) w_coef = r_active[i];
    end
  end

  logic signed [XW+COEFW-1:0] w_prodFull;
  logic signed [OUTW-1:0]     w_prodExt;
  assign w_prodFull = inX * w_coef;
  assign w_prodExt  = OUTW'(w_prodFull);

  logic signed [OUTW-1:0] r_prod;
  logic signed [OUTW-1:0] r_sumD;
  logic signed [OUTW-1:0] r_acc;
  logic                   r_v1;
  logic                   r_v2;

  // Two-stage MAC. Invalid cycles carry zeros, so the output reads 0 in gaps.
  // The add wraps modulo 2^OUTW.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prod <= '0;
      r_sumD <= '0;
      r_v1   <= 1'b0;
      r_acc  <= '0;
      r_v2   <= 1'b0;
    end else begin
      r_prod <= in_valid ? w_prodExt : '0;
      r_sumD <= in_valid ? inSum : '0;
      r_v1   <= in_valid;
      r_acc  <= r_sumD + r_prod;
      r_v2   <= r_v1;
    end
  end

  // Extra sum-path delay aligns this tap with the sum path of the chain.
  if (SUM_SHIFT > 2) begin : g_sumTail
    localparam int TD = SUM_SHIFT - 2;
    logic signed [OUTW-1:0] r_sumPipe [TD];
    logic                   r_vPipe   [TD];
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int i = 0; i < TD; i++) begin
          r_sumPipe[i] <= '0;
          r_vPipe[i]   <= 1'b0;
        end
      end else begin
        r_sumPipe[0] <= r_acc;
        r_vPipe[0]   <= r_v2;
        for (int i = 1; i < TD; i++) begin
          r_sumPipe[i] <= r_sumPipe[i-1];
          r_vPipe[i]   <= r_vPipe[i-1];
        end
      end
    end
    assign outSum       = r_sumPipe[TD-1];
    assign outSum_valid = r_vPipe[TD-1];
  end else begin : g_sumDirect
    assign outSum       = r_acc;
    assign outSum_valid = r_v2;
  end

  logic signed [XW-1:0] r_xPipe  [SAMPLE_SHIFT];
  logic [CHW-1:0]       r_chPipe [SAMPLE_SHIFT];
  logic                 r_vxPipe [SAMPLE_SHIFT];

  // The sample path shifts every clock, whether or not the input is valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SAMPLE_SHIFT; i++) begin
        r_xPipe[i]  <= '0;
        r_chPipe[i] <= '0;
        r_vxPipe[i] <= 1'b0;
      end
    end else begin
      r_xPipe[0]  <= inX;
      r_chPipe[0] <= in_ch;
      r_vxPipe[0] <= in_valid;
      for (int i = 1; i < SAMPLE_SHIFT; i++) begin
        r_xPipe[i]  <= r_xPipe[i-1];
        r_chPipe[i] <= r_chPipe[i-1];
        r_vxPipe[i] <= r_vxPipe[i-1];
      end
    end
  end

  assign outX       = r_xPipe[SAMPLE_SHIFT-1];
  assign outX_ch    = r_chPipe[SAMPLE_SHIFT-1];
  assign outX_valid = r_vxPipe[SAMPLE_SHIFT-1];

endmodule

// File: tb/tb_firtap_mc.sv
// tb_firtap_mc -- scoreboard bench for firtap_mc.
// dutA uses the default single-channel configuration (NCH=1, SUM_SHIFT=2,
// SAMPLE_SHIFT=1). dutB is interleaved (NCH=4, SUM_SHIFT=4, SAMPLE_SHIFT=2).
// Stimulus pushes hand-computed expected results, each with its arrival
// cycle, into queues. A monitor pops an entry whenever a DUT raises a valid
// output and compares it.
module tb_firtap_mc;

  typedef struct {
    int          cyc;
    logic [47:0] sum;
  } sumExp_t;

  typedef struct {
    int          cyc;
    logic [1:0]  ch;
    logic [17:0] x;
  } xExp_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic               aInValid, aOutXValid, aOutSumValid, aCoefWr, aCoefSwap;
  logic               aInCh, aOutXCh, aCoefWrCh;
  logic signed [17:0] aInX, aOutX;
  logic signed [47:0] aInSum, aOutSum;
  logic signed [24:0] aCoefWrData;

  logic               bInValid, bOutXValid, bOutSumValid, bCoefWr, bCoefSwap;
  logic [1:0]         bInCh, bOutXCh, bCoefWrCh;
  logic signed [17:0] bInX, bOutX;
  logic signed [47:0] bInSum, bOutSum;
  logic signed [24:0] bCoefWrData;

  firtap_mc dutA (
    .clk(clk), .rstn(rstn),
    .in_valid(aInValid), .in_ch(aInCh), .inX(aInX), .inSum(aInSum),
    .outX_valid(aOutXValid), .outX_ch(aOutXCh), .outX(aOutX),
    .outSum_valid(aOutSumValid), .outSum(aOutSum),
    .coef_wr(aCoefWr), .coef_wr_ch(aCoefWrCh), .coef_wr_data(aCoefWrData),
    .coef_swap(aCoefSwap)
  );

  firtap_mc #(.NCH(4), .SAMPLE_SHIFT(2), .SUM_SHIFT(4)) dutB (
    .clk(clk), .rstn(rstn),
    .in_valid(bInValid), .in_ch(bInCh), .inX(bInX), .inSum(bInSum),
    .outX_valid(bOutXValid), .outX_ch(bOutXCh), .outX(bOutX),
    .outSum_valid(bOutSumValid), .outSum(bOutSum),
    .coef_wr(bCoefWr), .coef_wr_ch(bCoefWrCh), .coef_wr_data(bCoefWrData),
    .coef_swap(bCoefSwap)
  );

  sumExp_t qSumA[$];
  sumExp_t qSumB[$];
  xExp_t   qXA[$];
  xExp_t   qXB[$];
  sumExp_t se;
  xExp_t   xe;
  int      checks = 0;
  int      errors = 0;
  int      cycleCnt = 0;
  bit      endCheck = 1'b0;

  // Cycle counter used to timestamp expected arrivals.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  // Monitor: checks the reset state while reset is held. Otherwise it pops
  // and compares on every valid output, and requires outSum to be zero in gaps.
  always @(negedge clk) begin
    if (!rstn) begin
      checkOutput("resetA", 128'({aOutXValid, aOutXCh, aOutX, aOutSumValid, aOutSum}), 128'(0));
      checkOutput("resetB", 128'({bOutXValid, bOutXCh, bOutX, bOutSumValid, bOutSum}), 128'(0));
    end else begin
      if (aOutSumValid) begin
        if (qSumA.size() == 0) checkOutput("sumA_spurious", 128'(aOutSumValid), 128'(0));
        else begin
          se = qSumA.pop_front();
          checkOutput("sumA", 128'({cycleCnt, aOutSum}), 128'({se.cyc, se.sum}));
        end
      end else checkOutput("sumA_gap", 128'(aOutSum), 128'(0));
      if (aOutXValid) begin
        if (qXA.size() == 0) checkOutput("xA_spurious", 128'(aOutXValid), 128'(0));
        else begin
          xe = qXA.pop_front();
          checkOutput("xA", 128'({cycleCnt, 1'b0, aOutXCh, aOutX}), 128'({xe.cyc, xe.ch, xe.x}));
        end
      end
      if (bOutSumValid) begin
        if (qSumB.size() == 0) checkOutput("sumB_spurious", 128'(bOutSumValid), 128'(0));
        else begin
          se = qSumB.pop_front();
          checkOutput("sumB", 128'({cycleCnt, bOutSum}), 128'({se.cyc, se.sum}));
        end
      end else checkOutput("sumB_gap", 128'(bOutSum), 128'(0));
      if (bOutXValid) begin
        if (qXB.size() == 0) checkOutput("xB_spurious", 128'(bOutXValid), 128'(0));
        else begin
          xe = qXB.pop_front();
          checkOutput("xB", 128'({cycleCnt, bOutXCh, bOutX}), 128'({xe.cyc, xe.ch, xe.x}));
        end
      end
      if (endCheck)
        checkOutput("queuesEmpty", 128'(qSumA.size() + qSumB.size() + qXA.size() + qXB.size()), 128'(0));
    end
  end

  task automatic clearInputs();
    aInValid = 0; aInCh = 0; aInX = 0; aInSum = 0;
    aCoefWr = 0; aCoefWrCh = 0; aCoefWrData = 0; aCoefSwap = 0;
    bInValid = 0; bInCh = 0; bInX = 0; bInSum = 0;
    bCoefWr = 0; bCoefWrCh = 0; bCoefWrData = 0; bCoefSwap = 0;
  endtask

  // Sets coefficient controls for the next edge, which applyStimulus consumes.
  task automatic setCoef(input bit useB, input logic wr, input logic [1:0] wrCh,
                         input logic signed [24:0] data, input logic swap);
    if (useB) begin
      bCoefWr = wr; bCoefWrCh = wrCh; bCoefWrData = data; bCoefSwap = swap;
    end else begin
      aCoefWr = wr; aCoefWrCh = wrCh[0]; aCoefWrData = data; aCoefSwap = swap;
    end
  endtask

  // Drives one cycle, records expectations and leaves all inputs idle after the edge.
  task automatic applyStimulus(input bit useB, input logic v, input logic [1:0] ch,
                               input logic signed [17:0] x, input logic [47:0] s,
                               input bit pushSum, input logic [47:0] expSum, input bit pushX);
    if (useB) begin
      bInValid = v; bInCh = ch; bInX = x; bInSum = s;
      if (pushSum) qSumB.push_back('{cyc: cycleCnt + 4, sum: expSum});
      if (pushX) qXB.push_back('{cyc: cycleCnt + 2, ch: ch, x: x});
    end else begin
      aInValid = v; aInCh = ch[0]; aInX = x; aInSum = s;
      if (pushSum) qSumA.push_back('{cyc: cycleCnt + 2, sum: expSum});
      if (pushX) qXA.push_back('{cyc: cycleCnt + 1, ch: {1'b0, ch[0]}, x: x});
    end
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic sampleA(input logic [1:0] ch, input logic signed [17:0] x,
                         input logic [47:0] s, input logic [47:0] expSum);
    applyStimulus(1'b0, 1'b1, ch, x, s, 1'b1, expSum, 1'b1);
  endtask

  task automatic sampleB(input logic [1:0] ch, input logic signed [17:0] x,
                         input logic [47:0] s, input logic [47:0] expSum);
    applyStimulus(1'b1, 1'b1, ch, x, s, 1'b1, expSum, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 2'd0, 18'sd0, 48'd0, 1'b0, 48'd0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held with garbage on every input.
    rstn = 1'b0;
    clearInputs();
    aInValid = 1'b1; aInX = 18'($urandom()); aInSum = 48'({$urandom(), $urandom()});
    aCoefWr = 1'b1; aCoefWrData = 25'($urandom()); aCoefSwap = 1'b1;
    bInValid = 1'b1; bInCh = 2'($urandom()); bInX = 18'($urandom());
    bInSum = 48'({$urandom(), $urandom()}); bCoefWr = 1'b1; bCoefWrData = 25'($urandom());
    bCoefSwap = 1'b1;
    repeat (3) @(posedge clk);
    #1 clearInputs();
    @(posedge clk);
    #1 rstn = 1'b1;
    idle(2);

    // dutA: a swap of the empty shadow bank leaves the coefficients at 0, so outSum = inSum.
    setCoef(0, 0, 0, 0, 1); sampleA(0, 18'sd7, 48'd100, 48'd100);
    sampleA(0, 18'sd9, 48'd55, 48'd55);
    // Coefficient 3: 5*3 + 10 = 25.
    setCoef(0, 1, 0, 25'sd3, 0); idle(1);
    setCoef(0, 0, 0, 0, 1); idle(1);
    sampleA(0, 18'sd5, 48'd10, 48'd25);
    // Signed product: (-2)*(-4) = 8.
    setCoef(0, 1, 0, -25'sd4, 0); idle(1);
    setCoef(0, 0, 0, 0, 1); idle(1);
    sampleA(0, -18'sd2, 48'd0, 48'd8);
    // Wrap: (2^47 - 1) + 1 gives -2^47.
    setCoef(0, 1, 0, 25'sd1, 0); idle(1);
    setCoef(0, 0, 0, 0, 1); idle(1);
    sampleA(0, 18'sd1, 48'h7FFF_FFFF_FFFF, 48'h8000_0000_0000);
    // Channel 1 does not exist: product 0, and the tag is still forwarded.
    sampleA(1, 18'sd1, 48'd5, 48'd5);
    // Write to nonexistent channel 1 is ignored, so the coefficient stays 1.
    setCoef(0, 1, 1, 25'sd50, 0); idle(1);
    setCoef(0, 0, 0, 0, 1); idle(1);
    sampleA(0, 18'sd1, 48'd0, 48'd1);
    // Gap pattern 1,0,1.
    sampleA(0, 18'sd2, 48'd3, 48'd5);
    idle(1);
    sampleA(0, 18'sd4, 48'd1, 48'd5);
    // Shadow write without swap changes nothing. At the swap edge the old
    // coefficient still applies; the new one applies from the next edge.
    setCoef(0, 1, 0, 25'sd20, 0); sampleA(0, 18'sd3, 48'd0, 48'd3);
    sampleA(0, 18'sd3, 48'd0, 48'd3);
    setCoef(0, 0, 0, 0, 1); sampleA(0, 18'sd3, 48'd0, 48'd3);
    sampleA(0, 18'sd3, 48'd0, 48'd60);
    // Write+swap together: active gets shadow 7 and shadow gets 9; the next swap makes 9 active.
    setCoef(0, 1, 0, 25'sd7, 0); idle(1);
    setCoef(0, 1, 0, 25'sd9, 1); sampleA(0, 18'sd1, 48'd0, 48'd20);
    sampleA(0, 18'sd1, 48'd0, 48'd7);
    setCoef(0, 0, 0, 0, 1); sampleA(0, 18'sd1, 48'd0, 48'd7);
    sampleA(0, 18'sd1, 48'd0, 48'd9);
    idle(3);

    // dutB: coefficients {1,2,3,4}; two rounds of channels 0..3 with inX=10.
    for (int c = 0; c < 4; c++) begin
      setCoef(1, 1, 2'(c), 25'(c + 1), 0); idle(1);
    end
    setCoef(1, 0, 0, 0, 1); idle(1);
    for (int r = 0; r < 2; r++) begin
      sampleB(2'd0, 18'sd10, 48'd0, 48'd10);
      sampleB(2'd1, 18'sd10, 48'd0, 48'd20);
      sampleB(2'd2, 18'sd10, 48'd0, 48'd30);
      sampleB(2'd3, 18'sd10, 48'd0, 48'd40);
    end
    idle(6);

    // Reset with three samples in flight. Only the first sample's forwarded
    // value leaves dutB before reset; nothing may emerge after release.
    applyStimulus(1'b1, 1'b1, 2'd0, 18'sd10, 48'd0, 1'b0, 48'd0, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'd1, 18'sd10, 48'd0, 1'b0, 48'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd2, 18'sd10, 48'd0, 1'b0, 48'd0, 1'b0);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    idle(8);

    // Reset cleared both banks: swapping the empty shadow gives outSum = inSum.
    setCoef(1, 0, 0, 0, 1); idle(1);
    sampleB(2'd2, 18'sd5, 48'd77, 48'd77);
    idle(8);

    endCheck = 1'b1;
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
